// File: rtl/ahb_apb_pkg.sv
// Shared constants and types for the AHB-to-APB bridge: transfer/response encodings,
// the AHB error-response state type and the one-hot peripheral select codes.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_P0   = 3'b001;
    localparam logic [2:0] SEL_P1   = 3'b010;
    localparam logic [2:0] SEL_P2   = 3'b100;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational AHB address decoder: range check against the bridge window and
// one-hot selection of one of three equally sized peripheral slots.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          SLOT_SHIFT = 26,
    parameter int          NUM_SLOTS  = 3
) (
    input  logic [31:0] Haddr,
    output logic        mapped,
    output logic [2:0]  tempselx
);

    // Window limit kept at 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(NUM_SLOTS) << SLOT_SHIFT);

    logic [31:0] offset;
    logic [31:0] slot;

    assign mapped = ({1'b0, Haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, Haddr} < LIMIT);
    assign offset = Haddr - BASE_ADDR;
    assign slot   = offset >> SLOT_SHIFT;

    always_comb begin
        tempselx = SEL_NONE;
        if (mapped) begin
            case (slot)
                32'd0:   tempselx = SEL_P0;
                32'd1:   tempselx = SEL_P1;
                32'd2:   tempselx = SEL_P2;
                default: tempselx = SEL_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, address/data
// pipeline, two-cycle ERROR response. Define AHB_HRDATA_REG_EN to register Hrdata.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          SLOT_SHIFT = 26,
    parameter int          NUM_SLOTS  = 3
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Hready_err
);

    err_state_t state;
    logic       mapped;
    logic       xfer;
    logic       err_hit;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLOT_SHIFT(SLOT_SHIFT),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_decode (
        .Haddr   (Haddr),
        .mapped  (mapped),
        .tempselx(tempselx)
    );

    assign xfer    = Hreadyin && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
    assign err_hit = xfer && !mapped;
    assign valid   = xfer && mapped && (state != ST_ERR1);

    // Address/data pipeline: stage 1 and stage 2, frozen while the bus is stalled.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    // Error FSM; Hresp/Hready_err are loaded with the decode of the next state.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= ST_OK;
            Hresp      <= HRESP_OKAY;
            Hready_err <= 1'b1;
        end else begin
            case (state)
                ST_OK: begin
                    if (err_hit) begin
                        state      <= ST_ERR1;
                        Hresp      <= HRESP_ERROR;
                        Hready_err <= 1'b0;
                    end else begin
                        Hresp      <= HRESP_OKAY;
                        Hready_err <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    Hresp      <= HRESP_ERROR;
                    Hready_err <= 1'b1;
                end
                ST_ERR2: begin
                    if (err_hit) begin
                        state      <= ST_ERR1;
                        Hresp      <= HRESP_ERROR;
                        Hready_err <= 1'b0;
                    end else begin
                        state      <= ST_OK;
                        Hresp      <= HRESP_OKAY;
                        Hready_err <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_OK;
                    Hresp      <= HRESP_OKAY;
                    Hready_err <= 1'b1;
                end
            endcase
        end
    end

`ifdef AHB_HRDATA_REG_EN
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) Hrdata <= '0;
        else          Hrdata <= Prdata;
    end
`else
    assign Hrdata = Prdata;
`endif

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- Upstream AHB-side stage of the AHB-to-APB bridge. It sits directly in front of the APB FSM controller.
- Qualifies AHB transfers and decodes the peripheral select. It pipelines address, write data and the write flag into the Haddr1/Haddr2, Hwdata1/Hwdata2 and Hwritereg signals the controller consumes.
- Generates the two-cycle AHB ERROR response for unmapped addresses.
- Returns APB read data to the AHB master.

Parameters:
- BASE_ADDR, 32'h8000_0000, start of the bridge address window.
- SLOT_SHIFT, 26, log2 of the per-peripheral region size (64 MiB).
- NUM_SLOTS, 3, number of APB peripherals. Fixed at 3 and one-hot encoded in tempselx.

Ports:
- Hclk  in  1  bridge clock, rising-edge.
- Hresetn  in  1  reset, asynchronous, active-low.
- Hwrite  in  1  AHB write flag (address phase).
- Hreadyin  in  1  AHB HREADY from the bus; a transfer is sampled only when it is 1.
- Htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Haddr  in  32  AHB address.
- Hwdata  in  32  AHB write data (data phase).
- Prdata  in  32  APB read data.
- valid  out  1  qualified, mapped transfer present this cycle.
- Haddr1  out  32  Haddr registered once.
- Haddr2  out  32  Haddr registered twice.
- Hwdata1  out  32  Hwdata registered once.
- Hwdata2  out  32  Hwdata registered twice.
- Hwritereg  out  1  Hwrite registered once.
- tempselx  out  3  one-hot peripheral select decoded from Haddr.
- Hrdata  out  32  read data to the AHB master.
- Hresp  out  2  AHB response: 00 OKAY, 01 ERROR.
- Hready_err  out  1  0 during the first error cycle, else 1. ANDed with the controller's Hreadyout at the top level.

Behaviour:
- All clocking on the rising edge of Hclk. Asynchronous reset when Hresetn=0.
- Reset values: Haddr1, Haddr2, Hwdata1, Hwdata2 = 0; Hwritereg = 0; error FSM = OK; Hresp = 00; Hready_err = 1; registered Hrdata = 0.
- Decode (combinational):
  - slot = (Haddr - BASE_ADDR) >> SLOT_SHIFT.
  - Mapped iff BASE_ADDR <= Haddr < BASE_ADDR + 3<<SLOT_SHIFT.
  - tempselx = 001, 010 or 100 for slot 0, 1 or 2; 000 when unmapped.
- valid (combinational) = Hreadyin & Htrans[1] & mapped & (state != ERR1).
  - IDLE and BUSY never assert valid.
- Pipeline (all registers hold when Hreadyin=0):
  - Haddr1 <= Haddr; Haddr2 <= Haddr1.
  - Hwdata1 <= Hwdata; Hwdata2 <= Hwdata1.
  - Hwritereg <= Hwrite.
  - Latency: Haddr to Haddr1 is 1 cycle; to Haddr2 is 2 cycles.
- Error FSM, states OK, ERR1, ERR2:
  - OK -> ERR1 when Hreadyin & Htrans[1] & !mapped.
  - ERR1 (Hresp=01, Hready_err=0) -> ERR2 unconditionally.
  - ERR2 (Hresp=01, Hready_err=1) -> ERR1 if another unmapped NONSEQ/SEQ is sampled; otherwise -> OK.
  - OK: Hresp=00, Hready_err=1.
  - Hresp and Hready_err are registered outputs decoded from the state.
- Simultaneous events:
  - A mapped transfer sampled in ERR2 asserts valid normally and the FSM returns to OK.
  - In ERR1, pipeline registers still follow Hreadyin; valid stays 0.
- Boundaries:
  - Haddr = BASE_ADDR - 1 is unmapped.
  - BASE_ADDR + 3<<SLOT_SHIFT is unmapped.
  - BASE_ADDR + (3<<SLOT_SHIFT) - 1 maps to slot 2.
  - Address subtraction is unsigned 32-bit; wrap below BASE_ADDR must be excluded by the range compare, not by the subtraction.
- Reset mid-operation: error FSM returns to OK immediately; all pipeline registers clear asynchronously.

Optional Feature:
- Macro: AHB_HRDATA_REG_EN.
- Defined: Hrdata <= Prdata on every rising edge, giving 1-cycle latency. Reset value is 0.
- Undefined: Hrdata = Prdata combinationally, with zero latency.
- The rest of the behaviour is identical in both builds.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ.
  - HRESP_OKAY, HRESP_ERROR.
  - the error-FSM state typedef.
  - the one-hot select constants SEL_P0, SEL_P1, SEL_P2.
- Sub-module: ahb_addr_decode, a combinational Haddr to {mapped, tempselx} decoder reused by the bench model.

Test Plan:
- Reset, then Htrans=00 with Hreadyin=1 -> valid=0, Hresp=00, Hready_err=1, Haddr1=0.
- NONSEQ write to Haddr=32'h8000_0004 with Hwdata=32'hDEADBEEF one cycle later:
  - same cycle: valid=1, tempselx=001;
  - next edge: Haddr1=32'h8000_0004, Hwritereg=1;
  - edge after: Haddr2=32'h8000_0004, Hwdata1=32'hDEADBEEF.
- Read from Haddr=32'h8400_0020 -> tempselx=010, valid=1; Hold Hreadyin=0 for 2 cycles -> Haddr1 and Haddr2 unchanged.
- NONSEQ to 32'h8C00_0000 (unmapped) -> valid=0, tempselx=000.
  - next cycle: Hresp=01, Hready_err=0;
  - following cycle: Hresp=01, Hready_err=1;
  - then Hresp=00.
- Back-to-back unmapped transfers 32'h7FFF_FFFC then 32'h8C00_0000 with the second sampled in ERR2 -> ERR1 re-entered, Hready_err=0 again.
- Prdata=32'hFACEFEED:
  - with AHB_HRDATA_REG_EN: Hrdata=32'hFACEFEED one edge later;
  - without it: Hrdata=32'hFACEFEED in the same cycle.
  - Deassert Hresetn mid-ERR1 -> Hresp=00, Hready_err=1 immediately.
